// File: rtl/uart_tx_fifo.sv
// Transmit-side FWFT byte buffer between the SBUF write path and the UART transmitter.
// Also generates the TI (transmit-done) interrupt flag and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_tx,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              r_en,
  output logic [DATA_W-1:0] txd_to_if,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_int,
  input  logic              ti_clr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;

  logic pop_ok;
  logic push_ok;
  logic drop;
  logic ti_set;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);

  always_comb begin
    txd_to_if = '0;
    if (!fifo_empty)
      txd_to_if = mem[rd_ptr];
  end

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // accepted when it coincides with a pop.
  always_comb begin
    pop_ok  = !flush && r_en && !fifo_empty;
    push_ok = !flush && wr_en && (!fifo_full || pop_ok);
    drop    = !flush && wr_en && fifo_full && !r_en;
    ti_set  = pop_ok && !push_ok && (level == {{ADDR_W{1'b0}}, 1'b1});
  end

  always_ff @(posedge clk_tx) begin
    if (rst_n && push_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_tx) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      tx_int   <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok)
          rd_ptr <= rd_ptr + ADDR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   level <= level + (ADDR_W+1)'(1);
          2'b01:   level <= level - (ADDR_W+1)'(1);
          default: level <= level;
        endcase
      end

      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;

      if (ti_set)
        tx_int <= 1'b1;
      else if (ti_clr)
        tx_int <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer that sits directly upstream of the UART interface. It accepts bytes from the 8051 SBUF write path and presents them first-word-fall-through to the UART transmitter, which pops one byte per frame. It also generates the transmit-done interrupt flag (TI) and a sticky overflow flag for the SFR block.

Parameters:
DATA_W, 8, byte width.
ADDR_W, 4, pointer width; depth = 2**ADDR_W = 16 entries.

Ports:
clk_tx  in  1  transmit bit clock (9600 Hz); all state updates on posedge.
rst_n  in  1  synchronous, active-low reset.
wr_en  in  1  push wr_data this cycle (one-cycle pulse per byte).
wr_data  in  DATA_W  byte to push.
flush  in  1  synchronous clear of contents.
r_en  in  1  pop request from the UART transmitter.
txd_to_if  out  DATA_W  head-of-queue byte, valid in the same cycle as r_en.
fifo_empty  out  1  no stored bytes.
fifo_full  out  1  2**ADDR_W bytes stored.
level  out  ADDR_W+1  number of stored bytes, 0..16.
overflow  out  1  sticky: a push was dropped.
ovf_clr  in  1  clears overflow.
tx_int  out  1  TI flag: last stored byte handed to the transmitter.
ti_clr  in  1  clears tx_int (software write to TI = 0).

Behaviour:
- Reset (rst_n = 0 at posedge):
  - rd_ptr, wr_ptr, level cleared to 0.
  - fifo_empty = 1, fifo_full = 0, overflow = 0, tx_int = 0, txd_to_if = 8'h00.
  - Memory contents are not reset.
- Storage and pointers:
  - DATA_W x 2**ADDR_W register array.
  - rd_ptr and wr_ptr are ADDR_W bits and wrap naturally from 15 to 0.
  - level is held as an explicit ADDR_W+1 counter.
  - fifo_empty = (level == 0); fifo_full = (level == 2**ADDR_W). Both are decoded combinationally from registered level.
- Read data:
  - txd_to_if = mem[rd_ptr] combinationally when not empty; 8'h00 when empty.
  - Zero latency, so the transmitter can latch txd_to_if in the cycle r_en is high.
- Push (wr_en & !fifo_full):
  - mem[wr_ptr] <= wr_data, wr_ptr++.
  - A byte written at edge N appears on txd_to_if after edge N if the queue was empty.
- Pop (r_en & !fifo_empty): rd_ptr++.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Both: level unchanged, both pointers advance.
- Boundary cases:
  - Push while full with no pop: byte dropped, state unchanged, overflow <= 1.
  - Push while full with a simultaneous pop: both occur, no overflow.
  - Pop while empty: ignored; pointers and level unchanged, no tx_int.
  - Push and pop in the same cycle while empty: pop ignored, push accepted, level becomes 1.
- Overflow flag:
  - Sticky until ovf_clr.
  - If ovf_clr and a new drop occur in the same cycle, set wins.
- tx_int:
  - Set (<= 1) when a pop occurs with level == 1 and no simultaneous push, i.e. the queue goes empty after handing off its last byte.
  - Holds until ti_clr; if ti_clr and set occur in the same cycle, set wins.
  - Pushing new data does not clear tx_int.
- Flush:
  - Same-cycle effect: pointers and level <= 0 at the next edge.
  - A wr_en or r_en in that cycle is ignored.
  - overflow and tx_int are unaffected.
- Priority: rst_n > flush > push/pop.
- All outputs are registered or decoded from registers; no combinational path from wr_en to txd_to_if.

Test Plan:
1. Reset, then push 8'hA5 with r_en = 0 -> after the edge: level = 1, fifo_empty = 0, txd_to_if = 8'hA5, tx_int = 0.
2. Push 8'h01..8'h10 (16 bytes), then push 8'hFF -> fifo_full = 1, level = 16, overflow = 1. Pop all 16 -> data out in order 8'h01..8'h10, never 8'hFF.
3. Fill to 16 entries, assert wr_en = 1 and r_en = 1 in the same cycle with 8'h55 -> level stays 16, overflow stays 0, 8'h55 is read last after the wrap-around of wr_ptr.
4. Queue holds one byte 8'h3C; pulse r_en -> fifo_empty = 1 and tx_int = 1 after the edge. Assert ti_clr and pop-to-empty in the same cycle -> tx_int stays 1.
5. Empty queue: assert r_en for 3 cycles -> level = 0, pointers unchanged, tx_int = 0, txd_to_if = 8'h00.
6. Fill 5 bytes, assert flush with wr_en = 1 -> level = 0, fifo_empty = 1, the write is discarded. Assert rst_n = 0 mid-operation -> all outputs return to their reset values at the next edge.
